// File: rtl/alu.sv
// Registered AND/OR/XOR/ADD unit with a carry flag.
// Result and carry appear one clock after the operands are sampled.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       alu_select,
    output logic [WIDTH-1:0] alu_output,
    output logic             alu_carry_out
);

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_ADD = 2'd3;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic             carry;

    // Sum is one bit wider so the carry falls out of the top bit.
    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (alu_select)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_ADD: {carry, result} = sum;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_output    <= '0;
            alu_carry_out <= 1'b0;
        end else begin
            alu_output    <= result;
            alu_carry_out <= carry;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed cases followed by random operations with occasional resets.
// Expected values come from an integer-arithmetic reference model.
module tb_alu;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   sel;
    logic [W-1:0] y;
    logic         co;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .a            (a),
        .b            (b),
        .alu_select   (sel),
        .alu_output   (y),
        .alu_carry_out(co)
    );

    function automatic void model(input int ai, input int bi, input int s, input bit r,
                                  output int ey, output int ec);
        int total;
        ey = 0;
        ec = 0;
        if (!r) begin
            case (s)
                0: ey = ai & bi;
                1: ey = ai | bi;
                2: ey = ai ^ bi;
                default: begin
                    total = ai + bi;
                    ey    = total % M;
                    ec    = (total >= M) ? 1 : 0;
                end
            endcase
        end
    endfunction

    task automatic check(input string tag, input int ey, input int ec);
        checks++;
        assert (y === W'(ey)) else begin
            failures++;
            $error("FAIL %s output actual=%0h required=%0h", tag, y, ey);
        end
        checks++;
        assert (co === 1'(ec)) else begin
            failures++;
            $error("FAIL %s carry actual=%0b required=%0b", tag, co, ec);
        end
    endtask

    // Present one operation, check it one edge later, then disturb the inputs
    // mid-cycle and check the registered outputs did not move.
    task automatic step(input string tag, input int ai, input int bi, input int s, input bit r);
        int ey, ec;
        @(negedge clk);
        a     = W'(ai);
        b     = W'(bi);
        sel   = 2'(s);
        reset = r;
        model(ai, bi, s, r, ey, ec);
        @(posedge clk);
        #1;
        check(tag, ey, ec);
        #1;
        a     = ~a;
        b     = ~b;
        sel   = sel + 2'd1;
        reset = ~reset;
        #1;
        check($sformatf("%s_hold", tag), ey, ec);
        reset = r;
    endtask

    initial begin
        reset = 1'b1;
        a     = '0;
        b     = '0;
        sel   = '0;

        step("rst0", 15, 15, 3, 1'b1);
        step("rst1", 15, 15, 3, 1'b1);
        step("rst_release_add", 15, 15, 3, 1'b0);

        step("and_ff", 15, 15, 0, 1'b0);
        step("and_00", 0, 0, 0, 1'b0);
        step("or_1e", 1, 14, 1, 1'b0);
        step("xor_e1", 14, 1, 2, 1'b0);
        step("add_ff", 15, 15, 3, 1'b0);
        step("add_78", 7, 8, 3, 1'b0);
        step("add_1f", 1, 15, 3, 1'b0);
        step("carry_set", 15, 15, 3, 1'b0);
        step("carry_clear", 15, 15, 0, 1'b0);

        for (int s = 0; s < 4; s++)
            step($sformatf("b2b_sel%0d", s), 10, 5, s, 1'b0);

        step("mid_rst_add", 15, 15, 3, 1'b1);
        step("post_rst_or", 10, 5, 1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step($sformatf("rand%0d", i), int'($urandom_range(0, M - 1)),
                 int'($urandom_range(0, M - 1)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
